// File: rtl/regbank_pkg.sv
// regbank_pkg: shared constants and types for the register bank.
//   DATA_W   - register / data-port width
//   ADDR_W   - register-select width
//   NUM_REGS - number of registers (2**ADDR_W)
//   ZERO_REG - index hardwired to read zero and to ignore writes (XZR)
package regbank_pkg;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int ZERO_REG = 31;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  localparam reg_addr_t ZERO_ADDR = reg_addr_t'(ZERO_REG);

endpackage

// File: rtl/regbank_read_port.sv
// regbank_read_port: one asynchronous read port of the register bank.
// Ports:
//   sel  - register select
//   regs - full storage array of the bank
//   data - selected register contents, forced to 0 when sel is the zero register
module regbank_read_port
  import regbank_pkg::*;
(
  input  reg_addr_t sel,
  input  reg_data_t regs [NUM_REGS],
  output reg_data_t data
);

  // Storage behind the zero register is never trusted; the force here is
  // what makes XZR read zero.
  always_comb begin
    data = regs[sel];
    if (sel == ZERO_ADDR) begin
      data = '0;
    end
  end

endmodule

// File: rtl/register_bank.sv
// register_bank: 32 x 64-bit register file, two async read ports, one
// synchronous write port. Register 31 reads zero and ignores writes.
// Ports:
//   clk       - system clock, rising edge
//   reset     - synchronous active-high reset, clears every register
//   register1 - read-port-1 select      dataout1 - register[register1]
//   register2 - read-port-2 select      dataout2 - register[register2]
//   register3 - write select
//   datain    - write data
//   regwrite  - write enable
// Reads are combinational with no write bypass: a same-cycle write to the
// selected register is only visible after the clock edge.
module register_bank
  import regbank_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] register1,
  input  logic [ADDR_W-1:0] register2,
  input  logic [ADDR_W-1:0] register3,
  input  logic [DATA_W-1:0] datain,
  input  logic              regwrite,
  output logic [DATA_W-1:0] dataout1,
  output logic [DATA_W-1:0] dataout2
);

  reg_data_t regs [NUM_REGS];
  logic      write_en;

  assign write_en = regwrite && (register3 != ZERO_ADDR);

  // Reset wins over a write on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_en) begin
      regs[register3] <= datain;
    end
  end

  regbank_read_port u_read1 (
    .sel  (register1),
    .regs (regs),
    .data (dataout1)
  );

  regbank_read_port u_read2 (
    .sel  (register2),
    .regs (regs),
    .data (dataout2)
  );

endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: self-checking bench for register_bank. A plain array
// holds the architectural register contents; every read is predicted from
// it and queued on exp_q before being compared.
module tb_register_bank;

  logic        clk;
  logic        reset;
  logic [4:0]  register1;
  logic [4:0]  register2;
  logic [4:0]  register3;
  logic [63:0] datain;
  logic        regwrite;
  logic [63:0] dataout1;
  logic [63:0] dataout2;

  int checks;
  int errors;

  logic [63:0] model [32];
  logic [63:0] exp_q [$];

  register_bank dut (
    .clk       (clk),
    .reset     (reset),
    .register1 (register1),
    .register2 (register2),
    .register3 (register3),
    .datain    (datain),
    .regwrite  (regwrite),
    .dataout1  (dataout1),
    .dataout2  (dataout2)
  );

  // ---------------- clock / reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_read(input logic [4:0] a);
    return (a == 5'd31) ? 64'h0 : model[a];
  endfunction

  task automatic check_reads(input string tag);
    exp_q.push_back(model_read(register1));
    exp_q.push_back(model_read(register2));
    check({tag, "_rd1"}, dataout1, exp_q.pop_front());
    check({tag, "_rd2"}, dataout2, exp_q.pop_front());
  endtask

  // ---------------- driver tasks ----------------
  // Drive selects only, settle, then compare reads.
  task automatic set_reads(input logic [4:0] a, input logic [4:0] b, input string tag);
    @(negedge clk);
    register1 = a;
    register2 = b;
    regwrite  = 1'b0;
    reset     = 1'b0;
    #1;
    check_reads(tag);
  endtask

  // One full clock: drive, check old values before the edge, update the
  // model from the architectural rules, check again after the edge.
  task automatic apply(input logic rst, input logic we, input logic [4:0] wa,
                       input logic [63:0] wd, input logic [4:0] ra1,
                       input logic [4:0] ra2, input string tag);
    @(negedge clk);
    reset     = rst;
    regwrite  = we;
    register3 = wa;
    datain    = wd;
    register1 = ra1;
    register2 = ra2;
    #1;
    check_reads({tag, "_pre"});
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 64'h0;
    end else if (we && wa != 5'd31) begin
      model[wa] = wd;
    end
    #1;
    check_reads({tag, "_post"});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    regwrite  = 1'b0;
    register1 = '0;
    register2 = '0;
    register3 = '0;
    datain    = '0;
    for (int i = 0; i < 32; i++) model[i] = 64'h0;

    // Reset for one edge; contents are undefined before it, so only the
    // post-edge reads are compared.
    @(negedge clk);
    reset = 1'b1;
    register1 = 5'd0;
    register2 = 5'd1;
    @(posedge clk);
    #1;
    check("reset_r0", dataout1, 64'h0);
    check("reset_r1", dataout2, 64'h0);
    for (int i = 0; i < 32; i++) begin
      set_reads(5'(i), 5'(31 - i), "reset_sweep");
    end

    // Basic write and read.
    apply(1'b0, 1'b1, 5'd2, 64'h123456789ABCDEF0, 5'd2, 5'd0, "basic");
    check("basic_val", dataout1, 64'h123456789ABCDEF0);
    check("basic_r0", dataout2, 64'h0);

    // Write disabled.
    apply(1'b0, 1'b0, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3, 5'd3, "wr_off");
    check("wr_off_val", dataout1, 64'h0);

    // Zero register ignores writes.
    apply(1'b0, 1'b1, 5'd31, 64'hDEADBEEF00000000, 5'd31, 5'd31, "xzr");
    check("xzr_val", dataout1, 64'h0);

    // Read during write: old value before the edge, new after.
    apply(1'b0, 1'b1, 5'd5, 64'hAAAA, 5'd5, 5'd2, "rdw_setup");
    @(negedge clk);
    register1 = 5'd5;
    register3 = 5'd5;
    datain    = 64'h5555;
    regwrite  = 1'b1;
    #1;
    check("rdw_before", dataout1, 64'hAAAA);
    @(posedge clk);
    model[5] = 64'h5555;
    #1;
    check("rdw_after", dataout1, 64'h5555);

    // Both ports on the same register.
    set_reads(5'd5, 5'd5, "same_sel");

    // Reset beats a same-edge write.
    apply(1'b1, 1'b1, 5'd4, 64'h1, 5'd4, 5'd2, "rst_prio");
    check("rst_prio_r4", dataout1, 64'h0);
    check("rst_prio_r2", dataout2, 64'h0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      logic        r;
      logic        w;
      logic [63:0] d;
      r = ($urandom_range(0, 49) == 0);
      w = ($urandom_range(0, 3) != 0);
      d = {$urandom, $urandom};
      apply(r, w, 5'($urandom_range(0, 31)), d,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), "rand");
    end

    // Final sweep of every register against the model.
    for (int i = 0; i < 32; i++) begin
      set_reads(5'(i), 5'(i ^ 5'h1f), "final_sweep");
    end

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
